fetch_stage: RTL and testbench

Instruction-fetch stage of the pipelined core, directly downstream of the next-address multiplexer. It holds the program counter and drives `SeqAddrOut = PC + 1` back to the multiplexer, loading the multiplexer's output as the new PC. It fetches instructions through a req/ack instruction-memory handshake and presents them to decode through the IF/ID register. Stall from the hazard unit and redirect-flush on taken branches/jumps are handled here.

---
 rtl/pipeline_pkg.sv | 14 +
 rtl/if_id_reg.sv | 33 +++
 rtl/fetch_stage.sv | 112 +++++++++++
 tb/tb_fetch_stage.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: fetch reset defaults and the fetch FSM state encoding.
package pipeline_pkg;

    localparam logic [31:0] DEFAULT_RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        HOLD  = 2'd2,
        DRAIN = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: flush has priority over load; resets to an invalid NOP.
module if_id_reg
    import pipeline_pkg::*;
#(
    parameter logic [31:0] NOP_INSTR = DEFAULT_NOP_INSTR
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        flush,
    input  logic [31:0] instr_in,
    input  logic [31:0] pc_in,
    output logic [31:0] instr,
    output logic [31:0] pc,
    output logic        valid
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instr <= NOP_INSTR;
            pc    <= '0;
            valid <= 1'b0;
        end else if (flush) begin
            instr <= NOP_INSTR;
            valid <= 1'b0;
        end else if (load) begin
            instr <= instr_in;
            pc    <= pc_in;
            valid <= 1'b1;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC, req/ack fetch FSM with stall hold buffer and redirect drain.
module fetch_stage
    import pipeline_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
    parameter logic [31:0] NOP_INSTR = DEFAULT_NOP_INSTR
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [31:0] NextAddrIn,
    output logic [31:0] SeqAddrOut,
    input  logic        RedirectIn,
    input  logic        StallIn,
    output logic        IMemReqOut,
    output logic [31:0] IMemAddrOut,
    input  logic        IMemAckIn,
    input  logic [31:0] IMemDataIn,
    output logic [31:0] InstrOut,
    output logic [31:0] PCOut,
    output logic        ValidOut
);

    fetch_state_t state;
    logic [31:0]  pc;
    logic [31:0]  drain_addr;
    logic [31:0]  hold_buf;
    logic         req;
    logic         load;
    logic         flush;
    logic [31:0]  load_instr;

    assign SeqAddrOut  = pc + 32'd1;
    assign IMemReqOut  = req;
    // A drained request keeps its original address even after the PC has moved on.
    assign IMemAddrOut = (state == DRAIN) ? drain_addr : pc;

    always_comb begin
        load       = 1'b0;
        flush      = RedirectIn;
        load_instr = IMemDataIn;
        case (state)
            REQ:  load = IMemAckIn && !StallIn && !RedirectIn;
            HOLD: begin
                load       = !StallIn && !RedirectIn;
                load_instr = hold_buf;
            end
            default: ;
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state      <= IDLE;
            pc         <= RESET_PC;
            drain_addr <= '0;
            hold_buf   <= '0;
            req        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (RedirectIn) pc <= NextAddrIn;
                    state <= REQ;
                    req   <= 1'b1;
                end
                REQ: begin
                    if (RedirectIn) begin
                        pc <= NextAddrIn;
                        if (!IMemAckIn) begin
                            drain_addr <= pc;
                            state      <= DRAIN;
                        end
                    end else if (IMemAckIn) begin
                        if (StallIn) begin
                            hold_buf <= IMemDataIn;
                            state    <= HOLD;
                            req      <= 1'b0;
                        end else begin
                            pc <= NextAddrIn;
                        end
                    end
                end
                HOLD: begin
                    if (RedirectIn || !StallIn) begin
                        if (RedirectIn) hold_buf <= '0;
                        pc    <= NextAddrIn;
                        state <= REQ;
                        req   <= 1'b1;
                    end
                end
                DRAIN: begin
                    if (RedirectIn) pc <= NextAddrIn;
                    if (IMemAckIn) state <= REQ;
                end
            endcase
        end
    end

    if_id_reg #(
        .NOP_INSTR(NOP_INSTR)
    ) u_if_id_reg (
        .clk     (Clk),
        .rst     (Reset),
        .load    (load),
        .flush   (flush),
        .instr_in(load_instr),
        .pc_in   (pc),
        .instr   (InstrOut),
        .pc      (PCOut),
        .valid   (ValidOut)
    );

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: reference model of the fetch protocol plus an IF/ID scoreboard.
module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        Clk;
    logic        Reset;
    logic [31:0] NextAddrIn;
    logic [31:0] SeqAddrOut;
    logic        RedirectIn;
    logic        StallIn;
    logic        IMemReqOut;
    logic [31:0] IMemAddrOut;
    logic        IMemAckIn;
    logic [31:0] IMemDataIn;
    logic [31:0] InstrOut;
    logic [31:0] PCOut;
    logic        ValidOut;

    fetch_stage #(
        .RESET_PC (32'h0000_0000),
        .NOP_INSTR(NOP)
    ) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .NextAddrIn (NextAddrIn),
        .SeqAddrOut (SeqAddrOut),
        .RedirectIn (RedirectIn),
        .StallIn    (StallIn),
        .IMemReqOut (IMemReqOut),
        .IMemAddrOut(IMemAddrOut),
        .IMemAckIn  (IMemAckIn),
        .IMemDataIn (IMemDataIn),
        .InstrOut   (InstrOut),
        .PCOut      (PCOut),
        .ValidOut   (ValidOut)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef enum int {M_IDLE, M_REQ, M_HOLD, M_DRAIN} model_state_t;

    model_state_t m_state;
    logic [31:0]  m_pc;
    logic [31:0]  m_daddr;
    logic [31:0]  m_buf;
    logic         m_valid;
    logic [63:0]  sb[$];

    int vectors;
    int miscompares;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One clock cycle: drive inputs, check fetch-side outputs, advance the model, check IF/ID after the edge.
    task automatic step(input logic ack, input logic stall, input logic redir,
                        input logic seq, input logic [31:0] target);
        logic [31:0] nxt;
        logic [31:0] maddr;
        logic        exp_req;
        logic        pushed;
        logic        flushed;
        logic [63:0] item;
        nxt     = seq ? m_pc + 32'd1 : target;
        exp_req = (m_state == M_REQ) || (m_state == M_DRAIN);
        maddr   = (m_state == M_DRAIN) ? m_daddr : m_pc;
        IMemAckIn  = ack;
        IMemDataIn = 32'hA0 + maddr;
        StallIn    = stall;
        RedirectIn = redir;
        NextAddrIn = nxt;
        #1;
        check_eq("req", {31'd0, IMemReqOut}, {31'd0, exp_req});
        if (exp_req) check_eq("addr", IMemAddrOut, maddr);
        check_eq("seq_addr", SeqAddrOut, m_pc + 32'd1);
        pushed  = 1'b0;
        flushed = 1'b0;
        case (m_state)
            M_IDLE: begin
                if (redir) begin
                    m_pc    = nxt;
                    flushed = 1'b1;
                end
                m_state = M_REQ;
            end
            M_REQ: begin
                if (redir) begin
                    flushed = 1'b1;
                    if (!ack) begin
                        m_daddr = m_pc;
                        m_state = M_DRAIN;
                    end
                    m_pc = nxt;
                end else if (ack && !stall) begin
                    sb.push_back({32'hA0 + m_pc, m_pc});
                    pushed = 1'b1;
                    m_pc   = nxt;
                end else if (ack) begin
                    m_buf   = 32'hA0 + m_pc;
                    m_state = M_HOLD;
                end
            end
            M_HOLD: begin
                if (redir) begin
                    flushed = 1'b1;
                    m_pc    = nxt;
                    m_state = M_REQ;
                end else if (!stall) begin
                    sb.push_back({m_buf, m_pc});
                    pushed  = 1'b1;
                    m_pc    = nxt;
                    m_state = M_REQ;
                end
            end
            M_DRAIN: begin
                if (redir) begin
                    flushed = 1'b1;
                    m_pc    = nxt;
                end
                if (ack) m_state = M_REQ;
            end
        endcase
        @(posedge Clk);
        #1;
        if (pushed) begin
            item = sb.pop_front();
            check_eq("instr", InstrOut, item[63:32]);
            check_eq("pc_out", PCOut, item[31:0]);
            check_eq("valid", {31'd0, ValidOut}, 32'd1);
            m_valid = 1'b1;
        end else if (flushed) begin
            check_eq("flush_valid", {31'd0, ValidOut}, 32'd0);
            check_eq("flush_instr", InstrOut, NOP);
            m_valid = 1'b0;
        end else begin
            check_eq("valid_hold", {31'd0, ValidOut}, {31'd0, m_valid});
        end
    endtask

    task automatic model_reset();
        m_state = M_IDLE;
        m_pc    = 32'h0;
        m_daddr = 32'h0;
        m_buf   = 32'h0;
        m_valid = 1'b0;
        sb.delete();
    endtask

    task automatic check_reset_values(input string tag);
        check_eq({tag, "_valid"}, {31'd0, ValidOut}, 32'd0);
        check_eq({tag, "_instr"}, InstrOut, NOP);
        check_eq({tag, "_pc"}, PCOut, 32'h0);
        check_eq({tag, "_req"}, {31'd0, IMemReqOut}, 32'd0);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        Reset      = 1'b1;
        NextAddrIn = '0;
        RedirectIn = 1'b0;
        StallIn    = 1'b0;
        IMemAckIn  = 1'b0;
        IMemDataIn = '0;
        model_reset();
        #1;
        check_reset_values("reset");
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        Reset = 1'b0;

        step(0, 0, 0, 1, 0);                 // IDLE cycle, no request
        repeat (5) step(1, 0, 0, 1, 0);      // zero-wait fetch of PC 0..4
        step(1, 1, 0, 1, 0);                 // ack at PC 5 under stall -> HOLD
        step(0, 1, 0, 1, 0);
        step(0, 1, 0, 1, 0);
        step(0, 0, 0, 1, 0);                 // stall drops: PC 5 presented
        step(1, 0, 0, 1, 0);                 // fetch at 6

        step(0, 0, 1, 0, 32'h40);            // redirect with request to 7 pending
        step(0, 0, 0, 1, 0);                 // still draining address 7
        step(1, 0, 0, 1, 0);                 // late ack for 7 discarded
        step(1, 0, 0, 1, 0);                 // target 0x40
        step(1, 0, 0, 1, 0);

        step(1, 1, 0, 1, 0);                 // ack at 0x42 under stall -> HOLD
        step(0, 1, 1, 0, 32'h80);            // redirect and stall together in HOLD
        step(1, 0, 0, 1, 0);                 // target 0x80

        step(1, 0, 1, 0, 32'hFFFF_FFFF);     // redirect coinciding with ack
        step(1, 0, 0, 1, 0);                 // fetch at FFFF_FFFF, seq addr wraps
        step(1, 0, 0, 1, 0);                 // fetch at 0

        step(0, 0, 1, 0, 32'h10);            // into DRAIN
        step(0, 0, 0, 1, 0);
        #2;
        Reset = 1'b1;
        #1;
        check_reset_values("async_reset");
        @(negedge Clk);
        Reset = 1'b0;
        model_reset();
        step(1, 0, 0, 1, 0);                 // stray ack in IDLE ignored
        step(1, 0, 0, 1, 0);
        step(1, 0, 0, 1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
